// File: rtl/vect_dispatch_if.sv
// Bundle of the scalar-pipeline, vector-core and status signals of vect_dispatch.
// slave is the dispatcher's view; master is the surrounding environment's view.
interface vect_dispatch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_B = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: an instruction moves into the buffer on a clock edge where
  // in_valid_i && in_ready_o; in_ready_o never depends on in_valid_i. The core
  // side is pulse-based: vreq_o issues, vready_i gates the next issue,
  // vrd_wr_en_i/xwb_valid_o are single-cycle result strobes.
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_instr_i;
  logic [DATA_WIDTH-1:0] in_rs1_i;
  logic [DATA_WIDTH-1:0] in_rs2_i;
  logic                  in_xwb_i;

  logic [DATA_WIDTH-1:0] vinstr_o;
  logic [DATA_WIDTH-1:0] vrs1_o;
  logic [DATA_WIDTH-1:0] vrs2_o;
  logic                  vreq_o;
  logic                  vready_i;
  logic [DATA_WIDTH-1:0] vrd_i;
  logic                  vrd_wr_en_i;

  logic                  xwb_valid_o;
  logic [4:0]            xwb_addr_o;
  logic [DATA_WIDTH-1:0] xwb_data_o;

  logic [CNT_B-1:0]      fifo_count_o;
  logic                  idle_o;
  logic                  err_o;
  logic [1:0]            dbg_state_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_rs1_i, in_rs2_i, in_xwb_i,
    input  vready_i, vrd_i, vrd_wr_en_i,
    output in_ready_o, vinstr_o, vrs1_o, vrs2_o, vreq_o,
    output xwb_valid_o, xwb_addr_o, xwb_data_o,
    output fifo_count_o, idle_o, err_o, dbg_state_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_rs1_i, in_rs2_i, in_xwb_i,
    output vready_i, vrd_i, vrd_wr_en_i,
    input  in_ready_o, vinstr_o, vrs1_o, vrs2_o, vreq_o,
    input  xwb_valid_o, xwb_addr_o, xwb_data_o,
    input  fifo_count_o, idle_o, err_o, dbg_state_o
  );
endinterface

// File: rtl/vect_dispatch.sv
// Buffers vector instructions, issues them one at a time to the vector core
// and routes the core's scalar result back to the scalar register file.
module vect_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  vect_dispatch_if.slave  bus
);
  localparam int CNT_B = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs1_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs2_mem   [FIFO_DEPTH];
  logic                  xwb_mem   [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_B-1:0]      count_q;
  logic                  push, issue;

  logic [DATA_WIDTH-1:0] vinstr_q, vrs1_q, vrs2_q;
  logic                  vreq_q;
  logic                  xwb_pending_q;
  logic [4:0]            rd_idx_q;
  logic                  xwb_valid_q;
  logic [4:0]            xwb_addr_q;
  logic [DATA_WIDTH-1:0] xwb_data_q;
  logic                  err_q;

  // A full buffer refuses a push even when the same edge pops an entry.
  assign bus.in_ready_o = (count_q < CNT_B'(FIFO_DEPTH));
  assign push           = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && bus.vready_i && !xwb_pending_q) begin
          issue   = 1'b1;
          state_d = S_SETTLE;
        end
      end
      // The core's ready still reflects the previous instruction here.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.vready_i && !xwb_pending_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Storage is not reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.in_instr_i;
      rs1_mem[wr_ptr_q]   <= bus.in_rs1_i;
      rs2_mem[wr_ptr_q]   <= bus.in_rs2_i;
      xwb_mem[wr_ptr_q]   <= bus.in_xwb_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, issue})
        2'b10:   count_q <= count_q + CNT_B'(1);
        2'b01:   count_q <= count_q - CNT_B'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Operands stay on the bus until the next issue; the core samples them late.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vinstr_q      <= '0;
      vrs1_q        <= '0;
      vrs2_q        <= '0;
      vreq_q        <= 1'b0;
      xwb_pending_q <= 1'b0;
      rd_idx_q      <= '0;
      xwb_valid_q   <= 1'b0;
      xwb_addr_q    <= '0;
      xwb_data_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      vreq_q      <= issue;
      xwb_valid_q <= bus.vrd_wr_en_i && xwb_pending_q;
      if (issue) begin
        vinstr_q <= instr_mem[rd_ptr_q];
        vrs1_q   <= rs1_mem[rd_ptr_q];
        vrs2_q   <= rs2_mem[rd_ptr_q];
        if (xwb_mem[rd_ptr_q]) begin
          xwb_pending_q <= 1'b1;
          rd_idx_q      <= instr_mem[rd_ptr_q][11:7];
        end
      end
      if (bus.vrd_wr_en_i) begin
        if (xwb_pending_q) begin
          xwb_pending_q <= 1'b0;
          xwb_addr_q    <= rd_idx_q;
          xwb_data_q    <= bus.vrd_i;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.vinstr_o     = vinstr_q;
  assign bus.vrs1_o       = vrs1_q;
  assign bus.vrs2_o       = vrs2_q;
  assign bus.vreq_o       = vreq_q;
  assign bus.xwb_valid_o  = xwb_valid_q;
  assign bus.xwb_addr_o   = xwb_addr_q;
  assign bus.xwb_data_o   = xwb_data_q;
  assign bus.fifo_count_o = count_q;
  assign bus.idle_o       = (state_q == S_IDLE) && (count_q == '0) && !xwb_pending_q;
  assign bus.err_o        = err_q;
  assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_vect_dispatch.sv
// Directed bench for vect_dispatch: issue order/payload and writebacks are
// checked against expected queues filled when stimulus is driven.
module tb_vect_dispatch;
  localparam int DW = 32;
  localparam int FD = 4;

  logic clk;
  logic resetn;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  int   last_vreq_cyc;

  logic [3*DW-1:0] exp_q[$];
  logic [DW+4:0]   wb_q[$];

  vect_dispatch_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  vect_dispatch #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;
  initial begin
    #500000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] instr, input logic [DW-1:0] rs1,
                      input logic [DW-1:0] rs2, input logic xwb);
    logic acc;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = instr;
    bus.in_rs1_i   = rs1;
    bus.in_rs2_i   = rs2;
    bus.in_xwb_i   = xwb;
    acc = bus.in_ready_o;
    if (acc) exp_q.push_back({instr, rs1, rs2});
    step(1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_vreq(input string tag, input int limit);
    int n = 0;
    while (!bus.vreq_o && n < limit) begin
      step(1);
      n++;
    end
    check(tag, bus.vreq_o, 1'b1);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (resetn && bus.vreq_o) begin
      check("vreq_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0)
        check("vreq_payload", {bus.vinstr_o, bus.vrs1_o, bus.vrs2_o}, exp_q.pop_front());
      if (last_vreq_cyc >= 0) check("vreq_spacing", (cyc - last_vreq_cyc) >= 3, 1'b1);
      last_vreq_cyc = cyc;
    end
    if (resetn && bus.xwb_valid_o) begin
      check("xwb_expected", wb_q.size() != 0, 1'b1);
      if (wb_q.size() != 0)
        check("xwb_payload", {bus.xwb_addr_o, bus.xwb_data_o}, wb_q.pop_front());
    end
  end

  initial begin
    logic [DW-1:0] rs1_c;
    logic [DW-1:0] instr_r;
    logic [DW-1:0] instr_d;
    logic [DW-1:0] instr_e;
    int n;
    pass_cnt = 0;
    total_cnt = 0;
    last_vreq_cyc = -1;
    resetn = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_instr_i = '0;
    bus.in_rs1_i = '0;
    bus.in_rs2_i = '0;
    bus.in_xwb_i = 1'b0;
    bus.vready_i = 1'b0;
    bus.vrd_i = '0;
    bus.vrd_wr_en_i = 1'b0;

    // reset state
    #2 resetn = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready_o, 1'b1);
    check("rst_vreq", bus.vreq_o, 1'b0);
    check("rst_count", bus.fifo_count_o, 0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_xwb_valid", bus.xwb_valid_o, 1'b0);
    check("rst_idle", bus.idle_o, 1'b1);
    step(3);
    resetn = 1'b1;
    step(1);

    // single op
    bus.vready_i = 1'b1;
    push(32'h0201_0057, $urandom, $urandom, 1'b0);
    check("single_count1", bus.fifo_count_o, 1);
    check("single_no_vreq_yet", bus.vreq_o, 1'b0);
    step(1);
    check("single_vreq", bus.vreq_o, 1'b1);
    check("single_vinstr", bus.vinstr_o, 32'h0201_0057);
    check("single_count0", bus.fifo_count_o, 0);
    step(1);
    check("single_vreq_pulse", bus.vreq_o, 1'b0);
    step(2);
    check("single_idle", bus.idle_o, 1'b1);

    // back-pressure
    bus.vready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0000_1057 + 32'(i << 12), $urandom, $urandom, 1'b0);
    check("bp_count4", bus.fifo_count_o, 4);
    check("bp_not_ready", bus.in_ready_o, 1'b0);
    push(32'hDEAD_0057, $urandom, $urandom, 1'b0);
    check("bp_count_still4", bus.fifo_count_o, 4);
    bus.vready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1);
      n++;
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_count0", bus.fifo_count_o, 0);

    // busy core
    rs1_c = $urandom;
    push(32'h0000_2057, rs1_c, $urandom, 1'b0);
    wait_vreq("busy_first_issue", 10);
    bus.vready_i = 1'b0;
    instr_d = 32'h0000_3057;
    push(instr_d, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("busy_no_vreq", bus.vreq_o, 1'b0);
      check("busy_rs1_stable", bus.vrs1_o, rs1_c);
      step(1);
    end
    bus.vready_i = 1'b1;
    step(1);
    check("busy_wait_to_idle", bus.vreq_o, 1'b0);
    step(1);
    check("busy_reissue", bus.vreq_o, 1'b1);
    check("busy_reissue_instr", bus.vinstr_o, instr_d);

    // scalar result
    instr_r = 32'h0000_02D7;
    instr_e = 32'h0000_4057;
    push(instr_r, $urandom, $urandom, 1'b1);
    push(instr_e, $urandom, $urandom, 1'b0);
    wait_vreq("xres_issue", 10);
    check("xres_instr", bus.vinstr_o, instr_r);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("xres_hold_next", bus.vreq_o, 1'b0);
      step(1);
    end
    bus.vrd_wr_en_i = 1'b1;
    bus.vrd_i = 32'h0000_00AB;
    wb_q.push_back({5'd5, 32'h0000_00AB});
    step(1);
    bus.vrd_wr_en_i = 1'b0;
    bus.vrd_i = '0;
    check("xres_valid", bus.xwb_valid_o, 1'b1);
    check("xres_addr", bus.xwb_addr_o, 5'd5);
    check("xres_data", bus.xwb_data_o, 32'h0000_00AB);
    check("xres_next_not_yet", bus.vreq_o, 1'b0);
    wait_vreq("xres_next_issue", 10);
    check("xres_next_instr", bus.vinstr_o, instr_e);
    check("xres_valid_pulse", bus.xwb_valid_o, 1'b0);
    check("xres_addr_hold", bus.xwb_addr_o, 5'd5);

    // spurious result
    n = 0;
    while (!bus.idle_o && n < 20) begin
      step(1);
      n++;
    end
    check("spur_idle", bus.idle_o, 1'b1);
    bus.vrd_wr_en_i = 1'b1;
    bus.vrd_i = 32'h0000_0055;
    step(1);
    bus.vrd_wr_en_i = 1'b0;
    check("spur_err", bus.err_o, 1'b1);
    check("spur_no_xwb", bus.xwb_valid_o, 1'b0);
    step(3);
    check("spur_err_sticky", bus.err_o, 1'b1);
    check("spur_data_hold", bus.xwb_data_o, 32'h0000_00AB);

    // reset mid-op
    push(32'h0000_01D7, $urandom, $urandom, 1'b1);
    wait_vreq("rmid_issue", 10);
    bus.vready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h0000_5057 + 32'(i << 12), $urandom, $urandom, 1'b0);
    step(2);
    check("rmid_count3", bus.fifo_count_o, 3);
    check("rmid_busy", bus.idle_o, 1'b0);
    resetn = 1'b0;
    exp_q.delete();
    wb_q.delete();
    #1;
    check("rmid_count0", bus.fifo_count_o, 0);
    check("rmid_in_ready", bus.in_ready_o, 1'b1);
    check("rmid_vinstr", bus.vinstr_o, 0);
    check("rmid_vrs1", bus.vrs1_o, 0);
    check("rmid_err", bus.err_o, 1'b0);
    check("rmid_xwb_addr", bus.xwb_addr_o, 0);
    check("rmid_xwb_data", bus.xwb_data_o, 0);
    step(2);
    last_vreq_cyc = -1;
    resetn = 1'b1;
    bus.vready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("rmid_no_vreq", bus.vreq_o, 1'b0);
      step(1);
    end
    bus.vrd_wr_en_i = 1'b1;
    step(1);
    bus.vrd_wr_en_i = 1'b0;
    check("rmid_pending_dropped", bus.err_o, 1'b1);
    check("rmid_no_xwb", bus.xwb_valid_o, 1'b0);

    // final report
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_wb_q_empty", wb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
